// File: rtl/autoconfig_host_if.sv
// Zorro II config-space bus between the AutoConfig initiator and its responders.
// Only the D15..D12 nibble lane is carried; the data bus floats high when undriven.
interface autoconfig_host_if;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw_n;
  logic [22:0] addr;
  logic [3:0]  dbus_out;
  logic        dbus_oe;
  logic [3:0]  dbus_in;

  modport master (output as_n, uds_n, lds_n, rw_n, addr, dbus_out, dbus_oe,
                  input  dbus_in);
  modport slave  (input  as_n, uds_n, lds_n, rw_n, addr, dbus_out, dbus_oe,
                  output dbus_in);
endinterface

// File: rtl/autoconfig_host.sv
// Standalone Zorro II AutoConfig initiator: probes each board in $E80000 space
// and either assigns it a 64K-aligned base from a fixed window or shuts it up.
module autoconfig_host #(
  parameter logic [7:0]  BASE_START = 8'h20,
  parameter logic [7:0]  BASE_END   = 8'hA0,
  parameter int unsigned MAX_BOARDS = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  autoconfig_host_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [2:0]        config_count,
  output logic [2:0]        shut_count,
  output logic [7:0]        next_free
);

  typedef enum logic [3:0] {
    IDLE, ARM, RD_TYPE, RD_SIZE, RD_MFG0, RD_MFG1, RD_MFG2, RD_MFG3,
    DECIDE, WR_LO, WR_HI, WR_SHUT
  } state_t;

  state_t     state;
  state_t     launch_op;
  logic [2:0] t;
  logic [1:0] type_hi;
  logic [2:0] size_code;
  logic       mfg_all_f;
  logic [3:0] base_hi;
  logic [8:0] size_units;
  logic [8:0] aligned;
  logic [8:0] end_addr;
  logic [3:0] handled;
  logic [3:0] launch_data;
  logic       present;
  logic       fits;
  logic       launch;
  logic       finish;
  logic       is_write;

  function automatic logic [22:0] cfg_addr(input state_t s);
    logic [7:0] off;
    case (s)
      RD_SIZE: off = 8'h02;
      RD_MFG0: off = 8'h10;
      RD_MFG1: off = 8'h12;
      RD_MFG2: off = 8'h14;
      RD_MFG3: off = 8'h16;
      WR_LO:   off = 8'h4A;
      WR_HI:   off = 8'h48;
      WR_SHUT: off = 8'h4C;
      default: off = 8'h00;
    endcase
    return {16'hE800, off[7:1]};
  endfunction

  assign bus.lds_n = 1'b1;

  // Allocation arithmetic and the choice of which bus cycle follows the current one.
  always_comb begin
    if (size_code == 3'd0) size_units = 9'd128;
    else                   size_units = 9'd1 << (size_code - 3'd1);
    aligned   = ({1'b0, next_free} + size_units - 9'd1) & ~(size_units - 9'd1);
    end_addr  = aligned + size_units;
    present   = (type_hi == 2'b11) && !mfg_all_f;
    fits      = end_addr <= {1'b0, BASE_END};
    handled   = {1'b0, config_count} + {1'b0, shut_count};
    is_write  = (state == WR_LO) || (state == WR_HI) || (state == WR_SHUT);
    launch    = 1'b0;
    finish    = 1'b0;
    launch_op = RD_TYPE;
    case (state)
      ARM:     launch = 1'b1;
      RD_TYPE: begin launch = (t == 3'd4); launch_op = RD_SIZE; end
      RD_SIZE: begin launch = (t == 3'd4); launch_op = RD_MFG0; end
      RD_MFG0: begin launch = (t == 3'd4); launch_op = RD_MFG1; end
      RD_MFG1: begin launch = (t == 3'd4); launch_op = RD_MFG2; end
      RD_MFG2: begin launch = (t == 3'd4); launch_op = RD_MFG3; end
      DECIDE: begin
        if (t == 3'd4) begin
          if (!present) finish = 1'b1;
          else begin
            launch    = 1'b1;
            launch_op = fits ? WR_LO : WR_SHUT;
          end
        end
      end
      WR_LO:   begin launch = (t == 3'd4); launch_op = WR_HI; end
      WR_HI, WR_SHUT: begin
        if (t == 3'd4) begin
          if (handled == 4'(MAX_BOARDS)) finish = 1'b1;
          else                           launch = 1'b1;
        end
      end
      default: ;
    endcase
    case (launch_op)
      WR_LO:   launch_data = aligned[3:0];
      WR_HI:   launch_data = base_hi;
      default: launch_data = 4'h0;
    endcase
  end

  // DECIDE carries T4 of the last manufacturer read, so the decision costs no extra clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      t            <= 3'd0;
      bus.as_n     <= 1'b1;
      bus.uds_n    <= 1'b1;
      bus.rw_n     <= 1'b1;
      bus.addr     <= 23'd0;
      bus.dbus_out <= 4'h0;
      bus.dbus_oe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      config_count <= 3'd0;
      shut_count   <= 3'd0;
      next_free    <= BASE_START;
      type_hi      <= 2'b00;
      size_code    <= 3'd0;
      mfg_all_f    <= 1'b0;
      base_hi      <= 4'h0;
    end else if (state == IDLE) begin
      if (start) begin
        state        <= ARM;
        busy         <= 1'b1;
        done         <= 1'b0;
        config_count <= 3'd0;
        shut_count   <= 3'd0;
        next_free    <= BASE_START;
      end
    end else if (finish) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b1;
      bus.as_n    <= 1'b1;
      bus.uds_n   <= 1'b1;
      bus.rw_n    <= 1'b1;
      bus.dbus_oe <= 1'b0;
    end else if (launch) begin
      if (state == DECIDE) begin
        if (fits) begin
          config_count <= config_count + 3'd1;
          next_free    <= end_addr[7:0];
          base_hi      <= aligned[7:4];
        end else begin
          shut_count   <= shut_count + 3'd1;
        end
      end
      state        <= launch_op;
      t            <= 3'd0;
      bus.addr     <= cfg_addr(launch_op);
      bus.rw_n     <= !((launch_op == WR_LO) || (launch_op == WR_HI) || (launch_op == WR_SHUT));
      bus.as_n     <= 1'b1;
      bus.uds_n    <= 1'b1;
      bus.dbus_oe  <= 1'b0;
      bus.dbus_out <= launch_data;
    end else begin
      t <= t + 3'd1;
      case (t)
        3'd0: begin
          bus.as_n    <= 1'b0;
          bus.uds_n   <= is_write;
          bus.dbus_oe <= is_write;
        end
        3'd1, 3'd2: bus.uds_n <= 1'b0;
        default: begin
          bus.as_n  <= 1'b1;
          bus.uds_n <= 1'b1;
        end
      endcase
      if (t == 3'd3) begin
        case (state)
          RD_TYPE: type_hi   <= bus.dbus_in[3:2];
          RD_SIZE: size_code <= bus.dbus_in[2:0];
          RD_MFG0: mfg_all_f <= (bus.dbus_in == 4'hF);
          RD_MFG1, RD_MFG2: mfg_all_f <= mfg_all_f & (bus.dbus_in == 4'hF);
          RD_MFG3: begin
            mfg_all_f <= mfg_all_f & (bus.dbus_in == 4'hF);
            state     <= DECIDE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/autoconfig_host.md
# autoconfig_host

Hardware Zorro II AutoConfig initiator for bench and bring-up rigs that have no Kickstart in the loop. It drives 68000-style byte bus cycles into the $E80000 config space and reads each board's type, size and manufacturer nibbles. It assigns 64K-aligned base addresses from a fixed Fast-RAM window, or shuts a board up when the window is full. It sits in place of the CPU/expansion.library side, directly facing one or more autoconfig responders on the expansion bus.

## Interface
- BASE_START, 8'h20, first free address in 64K units (A23..A16).
- BASE_END, 8'hA0, exclusive end of the window in 64K units.
- MAX_BOARDS, 7, boards handled per pass (1..7).
- CLK  in  1  bus clock; all logic uses rising edges.
- RESETn  in  1  asynchronous, active-low reset.
- START  in  1  sampled high while idle: begin a pass.
- ASn, UDSn, LDSn, RWn  out  1 each  bus strobes. LDSn is constant 1, because config space is on D15..D12 only.
- ADDR  out  23  A23..A1.
- DBUS_OUT  out  4  write data for D15..D12.
- DBUS_OE  out  1  high means DBUS_OUT drives D15..D12.
- DBUS_IN  in  4  D15..D12, pulled up, so an undriven bus reads 4'hF.
- BUSY  out  1  pass in progress.
- DONE  out  1  set at end of pass; cleared by the next accepted START.
- CONFIG_COUNT, SHUT_COUNT  out  3 each  boards given an address / boards shut up.
- NEXT_FREE  out  8  allocation pointer in 64K units.

## Operation
- All outputs are registered.
- Reset values: ASn=UDSn=LDSn=RWn=1, ADDR=0, DBUS_OUT=0, DBUS_OE=0, BUSY=0, DONE=0, both counts 0, NEXT_FREE=BASE_START.
- START while BUSY is ignored.
- Accepting START clears both counts and DONE, and reloads NEXT_FREE=BASE_START.
- Per-board sequence (state machine): IDLE → RD_TYPE($00) → RD_SIZE($02) → RD_MFG0..3($10,$12,$14,$16) → DECIDE → {WR_LO($4A) → WR_HI($48) | WR_SHUT($4C)} → next board, or FINISH.
- All six reads are always performed, even when the board turns out to be absent.
- A board is absent if type[3:2]≠2'b11, or if all four raw mfg nibbles are 4'hF (mfg ID 0).
- Absent board → FINISH. No writes are issued.
- Size decode from the size nibble, bits [2:0], in 64K units: 000=128, 001=1, 010=2, 011=4, 100=8, 101=16, 110=32, 111=64.
- Alignment: base = (NEXT_FREE + size − 1) & ~(size − 1). Computed 9 bits wide, together with end = base + size.
- end > BASE_END → WR_SHUT (data 4'h0) and SHUT_COUNT+1.
- Otherwise:
  - WR_LO writes base[3:0].
  - WR_HI writes base[7:4].
  - NEXT_FREE = end[7:0].
  - CONFIG_COUNT+1.
- After MAX_BOARDS boards have been handled (configured + shut up) → FINISH without further reads.
- FINISH: BUSY=0 and DONE=1 on the same edge.
- Reset mid-pass: all outputs return to reset values immediately and asynchronously, and the bus is released.

## Timing
- Every bus cycle is exactly 5 CLK cycles, T0..T4. There is no DTACK.
- T0: ADDR and RWn driven. Strobes high.
- Read:
  - T1..T3: ASn=0 and UDSn=0 together.
  - DBUS_IN sampled on the rising edge that ends T3.
  - T4: strobes high.
- Write:
  - T1: ASn=0, UDSn=1, DBUS_OE=1 with data valid.
  - T2..T3: UDSn=0.
  - T4: strobes high; data and OE held.
  - OE drops at the start of the next T0.
  - ASn must lead UDSn by exactly one CLK. Responders infer R/W from strobe state one clock after the fall of ASn.
- ADDR and RWn are stable from T0 through T4.
- START accepted on edge n → T0 of the first cycle begins at edge n+1.
- Absent first board: DONE rises 6×5 = 30 cycles after T0 of the first cycle.

## Test plan
- One 2MB board (type 4'hE, size 4'h6, mfg 16'h07DB, driven inverted on the bus), then absent → writes $4A=4'h0 then $48=4'h2. Second pass of reads sees all F. CONFIG_COUNT=1, NEXT_FREE=8'h40, DONE=1.
- Four 2MB boards then absent → bases $20, $40, $60, $80. CONFIG_COUNT=4, NEXT_FREE=8'hA0. The fifth read group is absent.
- 512K board (size 4'h4) then 2MB board → 512K at $20 ($4A=0, $48=2). 2MB aligns $28 up to $40. NEXT_FREE=8'h60.
- 8MB board (size 4'h0) → aligned base $80, end $100 > $A0 → single write to $4C. SHUT_COUNT=1, CONFIG_COUNT=0, NEXT_FREE=8'h20.
- No board (bus floats F) → no write cycles at all. DONE exactly 30 cycles after the first T0. In every write cycle, ASn falls exactly one CLK before UDSn.
- RESETn low during T2 of a write → ASn=UDSn=1 and DBUS_OE=0 without waiting for a CLK edge. After release, a START begins a fresh pass with counts 0.
